// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: drives the data-memory port and registers MEM/WB results.
// Latency: 1 cycle to wb_* for non-memory ops and zero-wait accesses; 1+N cycles for N wait states.
// Backpressure: stall is high while an access waits on dmem_ready; upstream inputs are held meanwhile.
//
// Ports:
//   clk, rst_n           : pipeline clock (rising edge), asynchronous active-low reset
//   alu_result, rs2_data : effective address / pass-through result, store data
//   rd_addr, reg_write   : destination register and its write enable
//   mem_read, mem_write  : load / store (both set means store), funct3 selects size and signedness
//   dmem_*               : request, write strobe, word address, byte enables, write data; ready/rdata back
//   forward_mem          : combinational alu_result for the Execute forwarding mux
//   stall                : freeze upstream stages
//   wb_data, wb_rd_addr, wb_reg_write : MEM/WB pipeline register
//   misalign_err, bus_err : one-cycle registered error pulses
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] forward_mem,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd_addr;
  logic        r_wb_reg_write;
  logic        r_misalign_err;
  logic        r_bus_err;

  logic        w_mem_op;
  logic        w_is_load;
  logic [1:0]  w_off;
  logic        w_half;
  logic        w_word;
  logic        w_misaligned;
  logic        w_timeout_hit;
  logic        w_req;
  logic        w_stall;
  logic        w_done;
  logic        w_timeout;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_sh;
  logic [31:0] w_load_val;

  // Store takes priority when both mem_read and mem_write are set.
  assign w_mem_op  = mem_read | mem_write;
  assign w_is_load = mem_read & ~mem_write;
  assign w_off     = alu_result[1:0];
  assign w_half    = (funct3[1:0] == 2'b01);
  assign w_word    = funct3[1];
  assign w_misaligned = (w_half & alu_result[0]) | (w_word & (|alu_result[1:0]));

  // The counter holds the number of WAIT cycles already spent; the one now
  // in progress brings it to w_cnt_inc.
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == LP_TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_misalign  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          if (w_misaligned) begin
            w_misalign = 1'b1;
          end else begin
            w_req = 1'b1;
            if (dmem_ready) begin
              w_done = 1'b1;
            end else begin
              w_stall     = 1'b1;
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = '0;
            end
          end
        end
      end
      S_WAIT: begin
        w_req     = 1'b1;
        w_cnt_nxt = w_cnt_inc;
        // A response arriving on the timeout cycle still completes normally.
        if (dmem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store lane steering; loads read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{rs2_data[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {w_off[1], 1'b0};
          w_wdata = {2{rs2_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = rs2_data;
        end
      endcase
    end
  end

  assign w_sh = dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load_val = w_sh;
    case (funct3)
      3'b000:  w_load_val = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100:  w_load_val = {24'd0, w_sh[7:0]};
      3'b001:  w_load_val = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101:  w_load_val = {16'd0, w_sh[15:0]};
      default: w_load_val = w_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_wb_data      <= '0;
      r_wb_rd_addr   <= '0;
      r_wb_reg_write <= 1'b0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_misalign_err <= w_misalign;
      r_bus_err      <= w_timeout;
      if (w_stall) begin
        // Bubble into WB while the access is outstanding.
        r_wb_reg_write <= 1'b0;
      end else begin
        r_wb_rd_addr   <= rd_addr;
        r_wb_reg_write <= reg_write & ~mem_write & ~w_misalign & ~w_timeout;
        r_wb_data      <= (w_done & w_is_load) ? w_load_val : alu_result;
      end
    end
  end

  // Request and stall are gated by rst_n so they drop the instant reset asserts.
  assign dmem_req     = w_req & rst_n;
  assign stall        = w_stall & rst_n;
  assign dmem_we      = mem_write;
  assign dmem_addr    = {alu_result[31:2], 2'b00};
  assign dmem_be      = w_be;
  assign dmem_wdata   = w_wdata;
  assign forward_mem  = alu_result;
  assign wb_data      = r_wb_data;
  assign wb_rd_addr   = r_wb_rd_addr;
  assign wb_reg_write = r_wb_reg_write;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, hand-written
// wait/timeout/reset sequences, then random instructions against a byte-level model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result, rs2_data;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_write, mem_read;
  logic [2:0]  funct3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] forward_mem;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write, misalign_err, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read), .funct3(funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .forward_mem(forward_mem), .stall(stall),
    .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] s, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic mr, input logic [2:0] f3);
    alu_result = a; rs2_data = s; rd_addr = rd;
    reg_write = rw; mem_write = mw; mem_read = mr; funct3 = f3;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction from a byte view of the returned word.
  function automatic logic [31:0] ref_load(input logic [31:0] rdv, input logic [2:0] f3,
                                           input int off);
    logic [7:0]  by [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) by[i] = rdv[8*i +: 8];
    case (f3)
      3'b000: return 32'($signed(by[off]));
      3'b100: return 32'(by[off]);
      3'b001: begin h = {by[off+1], by[off]}; return 32'($signed(h)); end
      3'b101: begin h = {by[off+1], by[off]}; return 32'(h); end
      default: return {by[3], by[2], by[1], by[0]};
    endcase
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic        rw, mw, mr;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_wb;
    logic        e_wbwe, e_mis;
  } vec_t;

  vec_t vt [15];

  task automatic run_random(input int n_instr);
    logic [2:0]  lf [5];
    logic [31:0] a, s, rdv, exp_wd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mw, mr, mem, mis, err_to, acc, exp_we;
    logic [3:0]  exp_be;
    int kind, size, off, w, end_c;
    lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;
    for (int n = 0; n < n_instr; n++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      s    = $urandom;
      rd   = 5'($urandom_range(0, 31));
      mw   = (kind == 3);
      mr   = (kind == 1) || (kind == 2);
      rw   = mw ? 1'($urandom_range(0, 1)) : 1'b1;
      f3   = mw ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      mem  = mw | mr;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off  = int'(a[1:0]);
      mis  = mem && ((off % size) != 0);
      acc  = mem && !mis;
      w    = $urandom_range(0, 6);
      end_c  = acc ? ((w <= TO) ? w : TO) : 0;
      err_to = acc && (w > TO);
      exp_be = mw ? 4'(((1 << size) - 1) << off) : 4'hF;
      exp_wd = (size == 1) ? {24'd0, s[7:0]} * 32'h0101_0101 :
               (size == 2) ? {16'd0, s[15:0]} * 32'h0001_0001 : s;
      rdv = '0;
      drive(a, s, rd, rw, mw, mr, f3);
      for (int c = 0; c <= end_c; c++) begin
        dmem_ready = acc && (c == w);
        dmem_rdata = $urandom;
        if (c == w) rdv = dmem_rdata;
        #4;
        chk1("rnd_stall", stall, c < end_c);
        chk1("rnd_req", dmem_req, acc);
        if (acc && c == 0) begin
          chk("rnd_addr", dmem_addr, a & 32'hFFFF_FFFC);
          chk("rnd_be", 32'(dmem_be), 32'(exp_be));
          chk1("rnd_we", dmem_we, mw);
          if (mw) chk("rnd_wdata", dmem_wdata, exp_wd);
        end
        tick();
      end
      dmem_ready = 1'b0;
      exp_we = rw & ~mw & ~mis & ~err_to;
      chk1("rnd_mis", misalign_err, mis);
      chk1("rnd_buserr", bus_err, err_to);
      chk1("rnd_wbwe", wb_reg_write, exp_we);
      if (!mis && !err_to) begin
        chk("rnd_wbrd", 32'(wb_rd_addr), 32'(rd));
        chk("rnd_wbdata", wb_data, (mr && !mw) ? ref_load(rdv, f3, off) : a);
      end
    end
  endtask

  initial begin
    vt[0]  = '{"alu",    32'h1234_5678, 32'h0,         5'd5,  1,0,0, 3'b000, 32'h0,         0,0,4'hF,32'h0,         32'h1234_5678, 1,0};
    vt[1]  = '{"lb",     32'h0000_0103, 32'h0,         5'd7,  1,0,1, 3'b000, 32'h80FF_0000, 1,0,4'hF,32'h0,         32'hFFFF_FF80, 1,0};
    vt[2]  = '{"lbu",    32'h0000_0103, 32'h0,         5'd7,  1,0,1, 3'b100, 32'h80FF_0000, 1,0,4'hF,32'h0,         32'h0000_0080, 1,0};
    vt[3]  = '{"lw_mis", 32'h0000_0301, 32'h0,         5'd8,  1,0,1, 3'b010, 32'h0,         0,0,4'hF,32'h0,         32'h0,         0,1};
    vt[4]  = '{"lhu",    32'h0000_0302, 32'h0,         5'd9,  1,0,1, 3'b101, 32'h80FF_0000, 1,0,4'hF,32'h0,         32'h0000_80FF, 1,0};
    vt[5]  = '{"lh",     32'h0000_0302, 32'h0,         5'd9,  1,0,1, 3'b001, 32'h80FF_0000, 1,0,4'hF,32'h0,         32'hFFFF_80FF, 1,0};
    vt[6]  = '{"lh_mis", 32'h0000_0001, 32'h0,         5'd10, 1,0,1, 3'b001, 32'h0,         0,0,4'hF,32'h0,         32'h0,         0,1};
    vt[7]  = '{"sb",     32'h0000_0105, 32'h1122_3344, 5'd0,  0,1,0, 3'b000, 32'h0,         1,1,4'b0010,32'h4444_4444, 32'h0,      0,0};
    vt[8]  = '{"sw",     32'h0000_0400, 32'hDEAD_BEEF, 5'd0,  0,1,0, 3'b010, 32'h0,         1,1,4'hF,32'hDEAD_BEEF, 32'h0,         0,0};
    vt[9]  = '{"lw",     32'h0000_0500, 32'h0,         5'd11, 1,0,1, 3'b010, 32'hCAFE_F00D, 1,0,4'hF,32'h0,         32'hCAFE_F00D, 1,0};
    vt[10] = '{"rw_st",  32'h0000_0600, 32'h0BAD_CAFE, 5'd12, 1,1,1, 3'b010, 32'h0,         1,1,4'hF,32'h0BAD_CAFE, 32'h0,         0,0};
    vt[11] = '{"sh_mis", 32'h0000_0003, 32'h0000_FFFF, 5'd0,  0,1,0, 3'b001, 32'h0,         0,1,4'hF,32'h0,         32'h0,         0,1};
    vt[12] = '{"lb_pos", 32'h0000_0101, 32'h0,         5'd13, 1,0,1, 3'b000, 32'h0000_7F00, 1,0,4'hF,32'h0,         32'h0000_007F, 1,0};
    vt[13] = '{"x0",     32'h55AA_55AA, 32'h0,         5'd0,  1,0,0, 3'b000, 32'h0,         0,0,4'hF,32'h0,         32'h55AA_55AA, 1,0};
    vt[14] = '{"sh_lo",  32'h0000_0200, 32'h1234_ABCD, 5'd0,  0,1,0, 3'b001, 32'h0,         1,1,4'b0011,32'hABCD_ABCD, 32'h0,      0,0};

    // Reset state, with a load presented so the request gating is visible.
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive(32'h0000_0100, 32'h0, 5'd1, 1, 0, 1, 3'b010);
    #2;
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    tick();
    chk("rst_wbdata", wb_data, 32'h0);
    chk("rst_wbrd", 32'(wb_rd_addr), 32'h0);
    chk1("rst_wbwe", wb_reg_write, 1'b0);
    chk1("rst_mis", misalign_err, 1'b0);
    chk1("rst_bus", bus_err, 1'b0);
    rst_n = 1'b1;
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0, 3'b000);
    tick();

    // Single-cycle vector table: every access gets dmem_ready in its first cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].alu, vt[i].rs2, vt[i].rd, vt[i].rw, vt[i].mw, vt[i].mr, vt[i].f3);
      dmem_ready = 1'b1;
      dmem_rdata = vt[i].rdata;
      #4;
      chk1({vt[i].nm, "_req"}, dmem_req, vt[i].e_req);
      chk1({vt[i].nm, "_stall"}, stall, 1'b0);
      chk({vt[i].nm, "_fwd"}, forward_mem, vt[i].alu);
      if (vt[i].e_req) begin
        chk({vt[i].nm, "_addr"}, dmem_addr, vt[i].alu & 32'hFFFF_FFFC);
        chk({vt[i].nm, "_be"}, 32'(dmem_be), 32'(vt[i].e_be));
        chk1({vt[i].nm, "_we"}, dmem_we, vt[i].e_we);
        if (vt[i].e_we) chk({vt[i].nm, "_wdata"}, dmem_wdata, vt[i].e_wdata);
      end
      tick();
      chk1({vt[i].nm, "_wbwe"}, wb_reg_write, vt[i].e_wbwe);
      chk({vt[i].nm, "_wbrd"}, 32'(wb_rd_addr), 32'(vt[i].rd));
      chk1({vt[i].nm, "_mis"}, misalign_err, vt[i].e_mis);
      chk1({vt[i].nm, "_bus"}, bus_err, 1'b0);
      if (vt[i].e_wbwe) chk({vt[i].nm, "_wbdata"}, wb_data, vt[i].e_wb);
    end
    dmem_ready = 1'b0;

    // SH with three wait states: request fields must hold steady throughout.
    drive(32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 0, 1, 0, 3'b001);
    for (int c = 0; c <= 3; c++) begin
      dmem_ready = (c == 3);
      #4;
      chk1("shw_stall", stall, c < 3);
      chk1("shw_req", dmem_req, 1'b1);
      chk1("shw_we", dmem_we, 1'b1);
      chk("shw_addr", dmem_addr, 32'h0000_0200);
      chk("shw_be", 32'(dmem_be), 32'hC);
      chk("shw_wdata", dmem_wdata, 32'hBEEF_BEEF);
      tick();
      chk1("shw_wbwe", wb_reg_write, 1'b0);
    end
    chk("shw_wbrd", 32'(wb_rd_addr), 32'd3);

    // LW with two wait states; only the data on the ready cycle may be used.
    drive(32'h0000_0700, 32'h0, 5'd14, 1, 0, 1, 3'b010);
    for (int c = 0; c <= 2; c++) begin
      dmem_ready = (c == 2);
      dmem_rdata = (c == 2) ? 32'h1357_9BDF : $urandom;
      #4;
      chk1("lww_stall", stall, c < 2);
      tick();
    end
    chk1("lww_wbwe", wb_reg_write, 1'b1);
    chk("lww_wbdata", wb_data, 32'h1357_9BDF);

    // Timeout: no response ever; bus_err one cycle after the TO-th WAIT cycle.
    drive(32'h0000_0800, 32'h0, 5'd15, 1, 0, 1, 3'b010);
    dmem_ready = 1'b0;
    for (int c = 0; c <= TO; c++) begin
      #4;
      chk1("to_stall", stall, c < TO);
      chk1("to_req", dmem_req, 1'b1);
      tick();
      chk1("to_bus", bus_err, c == TO);
      chk1("to_wbwe", wb_reg_write, 1'b0);
    end
    drive(32'h0000_0011, 32'h0, 5'd2, 0, 0, 0, 3'b000);
    tick();
    chk1("to_bus_pulse", bus_err, 1'b0);

    // Response on the timeout cycle itself completes normally.
    drive(32'h0000_0804, 32'h0, 5'd16, 1, 0, 1, 3'b010);
    for (int c = 0; c <= TO; c++) begin
      dmem_ready = (c == TO);
      dmem_rdata = 32'h0F0F_0F0F;
      #4;
      chk1("win_stall", stall, c < TO);
      tick();
    end
    dmem_ready = 1'b0;
    chk1("win_bus", bus_err, 1'b0);
    chk1("win_wbwe", wb_reg_write, 1'b1);
    chk("win_wbdata", wb_data, 32'h0F0F_0F0F);

    // Reset asserted while in WAIT, then a normal LW.
    drive(32'h0000_0900, 32'h0, 5'd17, 1, 0, 1, 3'b010);
    #4;
    chk1("rw_stall0", stall, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rw_req", dmem_req, 1'b0);
    chk1("rw_stall", stall, 1'b0);
    chk("rw_wbdata", wb_data, 32'h0);
    chk("rw_wbrd", 32'(wb_rd_addr), 32'h0);
    chk1("rw_wbwe", wb_reg_write, 1'b0);
    tick();
    rst_n = 1'b1;
    drive(32'h0000_0904, 32'h0, 5'd18, 1, 0, 1, 3'b010);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hA5A5_5A5A;
    #4;
    chk1("rw_after_req", dmem_req, 1'b1);
    chk1("rw_after_stall", stall, 1'b0);
    tick();
    dmem_ready = 1'b0;
    chk1("rw_after_wbwe", wb_reg_write, 1'b1);
    chk("rw_after_wbdata", wb_data, 32'hA5A5_5A5A);
    chk("rw_after_wbrd", 32'(wb_rd_addr), 32'd18);

    run_random(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
